// File: rtl/ds_pkg.sv
// ============================================================================
// Module      : ds_pkg
// Description : Shared types and constants for the 2x2 downsampling sequencer
//               and the MAR control decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ds_pkg;

  localparam int COORD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } ds_state_t;

  localparam logic [1:0] MAR_HOLD  = 2'b00;
  localparam logic [1:0] MAR_AC    = 2'b01;
  localparam logic [1:0] MAR_READ  = 2'b10;
  localparam logic [1:0] MAR_WRITE = 2'b11;

  // Source coordinate of a window tap: 2*base + offset, as a shift-and-insert.
  function automatic logic [COORD_W-1:0] rd_coord(input logic [COORD_W-1:0] base,
                                                   input logic              offset);
    return {base[COORD_W-2:0], offset};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ds_pix_counter.sv
// ============================================================================
// Module      : ds_pix_counter
// Description : Raster-order output pixel counter (orow/ocol) that wraps at
//               OUT_DIM-1; exposes the value it will hold after this edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ds_pix_counter
  import ds_pkg::*;
#(
  parameter int OUT_DIM = 128
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               inc,
  output logic [COORD_W-1:0] orow_nxt,
  output logic [COORD_W-1:0] ocol_nxt,
  output logic               last
);

  localparam logic [COORD_W-1:0] c_MAX = COORD_W'(OUT_DIM - 1);

  logic [COORD_W-1:0] r_orow;
  logic [COORD_W-1:0] r_ocol;

  always_comb begin
    orow_nxt = r_orow;
    ocol_nxt = r_ocol;
    if (clr) begin
      orow_nxt = '0;
      ocol_nxt = '0;
    end else if (inc) begin
      if (r_ocol == c_MAX) begin
        ocol_nxt = '0;
        orow_nxt = (r_orow == c_MAX) ? '0 : r_orow + 1'b1;
      end else begin
        ocol_nxt = r_ocol + 1'b1;
      end
    end
  end

  assign last = (r_orow == c_MAX) && (r_ocol == c_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_orow <= '0;
      r_ocol <= '0;
    end else begin
      r_orow <= orow_nxt;
      r_ocol <= ocol_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ds_addr_gen.sv
// ============================================================================
// Module      : ds_addr_gen
// Description : 2x2 downsampling address sequencer: four source reads then one
//               destination write per output pixel, all outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ds_addr_gen
  import ds_pkg::*;
#(
  parameter int IMG_DIM = 256
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               step,
  output logic [COORD_W-1:0] RRR_out,
  output logic [COORD_W-1:0] CRR_out,
  output logic [COORD_W-1:0] RWR_out,
  output logic [COORD_W-1:0] CWR_out,
  output logic [1:0]         addr_sel,
  output logic [1:0]         tap,
  output logic               last_tap,
  output logic               valid,
  output logic               busy,
  output logic               done
);

  localparam int OUT_DIM = IMG_DIM / 2;

  ds_state_t          r_state;
  ds_state_t          w_state_nxt;
  logic [1:0]         w_tap_nxt;
  logic               w_cnt_clr;
  logic               w_cnt_inc;
  logic               w_cnt_last;
  logic [COORD_W-1:0] w_orow_nxt;
  logic [COORD_W-1:0] w_ocol_nxt;

  logic [COORD_W-1:0] w_rrr_nxt;
  logic [COORD_W-1:0] w_crr_nxt;
  logic [COORD_W-1:0] w_rwr_nxt;
  logic [COORD_W-1:0] w_cwr_nxt;
  logic [1:0]         w_sel_nxt;
  logic               w_valid_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_last_nxt;

  ds_pix_counter #(
    .OUT_DIM (OUT_DIM)
  ) u_pix_counter (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr      (w_cnt_clr),
    .inc      (w_cnt_inc),
    .orow_nxt (w_orow_nxt),
    .ocol_nxt (w_ocol_nxt),
    .last     (w_cnt_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_tap_nxt   = tap;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = READ;
          w_tap_nxt   = 2'd0;
          w_cnt_clr   = 1'b1;
        end
      end
      READ: begin
        if (step) begin
          if (tap == 2'd3) begin
            w_tap_nxt   = 2'd0;
            w_state_nxt = WRITE;
          end else begin
            w_tap_nxt = tap + 2'd1;
          end
        end
      end
      WRITE: begin
        if (step) begin
          if (w_cnt_last) begin
            w_state_nxt = DONE;
          end else begin
            w_cnt_inc   = 1'b1;
            w_state_nxt = READ;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_tap_nxt   = 2'd0;
      end
    endcase

    // Outputs are precomputed from the next state so they land with it.
    w_sel_nxt   = MAR_HOLD;
    w_valid_nxt = 1'b0;
    w_busy_nxt  = (w_state_nxt != IDLE);
    w_done_nxt  = (w_state_nxt == DONE);
    w_last_nxt  = (w_state_nxt == READ) && (w_tap_nxt == 2'd3);
    w_rrr_nxt   = RRR_out;
    w_crr_nxt   = CRR_out;
    w_rwr_nxt   = RWR_out;
    w_cwr_nxt   = CWR_out;

    if (w_state_nxt == READ) begin
      w_sel_nxt   = MAR_READ;
      w_valid_nxt = 1'b1;
      w_rrr_nxt   = rd_coord(w_orow_nxt, w_tap_nxt[1]);
      w_crr_nxt   = rd_coord(w_ocol_nxt, w_tap_nxt[0]);
    end else if (w_state_nxt == WRITE) begin
      w_sel_nxt   = MAR_WRITE;
      w_valid_nxt = 1'b1;
      w_rwr_nxt   = w_orow_nxt;
      w_cwr_nxt   = w_ocol_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tap      <= 2'd0;
      RRR_out  <= '0;
      CRR_out  <= '0;
      RWR_out  <= '0;
      CWR_out  <= '0;
      addr_sel <= MAR_HOLD;
      last_tap <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      tap      <= w_tap_nxt;
      RRR_out  <= w_rrr_nxt;
      CRR_out  <= w_crr_nxt;
      RWR_out  <= w_rwr_nxt;
      CWR_out  <= w_cwr_nxt;
      addr_sel <= w_sel_nxt;
      last_tap <= w_last_nxt;
      valid    <= w_valid_nxt;
      busy     <= w_busy_nxt;
      done     <= w_done_nxt;
    end
  end

endmodule

`default_nettype wire
